// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared types and defaults for the multiplier issue scheduler.
//   state_e   - scheduler state (IDLE / BUSY / HOLD)
//   TAG_W_DEF - default ROB/destination tag width
package mul_sched_pkg;
  localparam int TAG_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // multiplier free
    BUSY = 2'd1,  // op in flight, waiting for mul_valid_out
    HOLD = 2'd2   // product ready, result buffer full, waiting for cdb_grant
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among NUM_REQ requesters.
//   i_req   - request vector
//   i_ptr   - highest-priority index; search runs upward from here with wrap
//   i_en    - grant enable; o_grant stays zero when low
//   o_grant - one-hot grant (zero when nothing requests or i_en=0)
//   o_idx   - index of the first requester found (valid whenever any request)
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_idx
);
  logic          w_found;
  logic [PW-1:0] w_cand;

  // NUM_REQ is a power of two, so PW-bit addition wraps for free.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = i_ptr + PW'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    if (i_en && w_found) o_grant[o_idx] = 1'b1;
  end
endmodule

// File: rtl/mul_scheduler.sv
// mul_scheduler: issue scheduler + one-entry result buffer for the shared
// 64-bit iterative multiplier.
//   clk, rst (sync, active low)
//   req_valid/req_a/req_b/req_tag -> requesters; req_ready one-hot grant
//   mul_valid_in/mul_a/mul_b      -> multiplier start and operands
//   mul_valid_out/mul_out         <- multiplier done level and product
//   cdb_req/cdb_tag/cdb_data      -> buffered result; cdb_grant accepts it
//   flush kills in-flight and buffered work; busy = state != IDLE
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][63:0]       req_a,
  input  logic [NUM_REQ-1:0][63:0]       req_b,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           mul_valid_in,
  output logic [63:0]                    mul_a,
  output logic [63:0]                    mul_b,
  input  logic                           mul_valid_out,
  input  logic [63:0]                    mul_out,
  output logic                           cdb_req,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [63:0]                    cdb_data,
  input  logic                           cdb_grant,
  input  logic                           flush,
  output logic                           busy
);
  localparam int PW = $clog2(NUM_REQ);

  state_e            r_state, w_state_nxt;
  logic [PW-1:0]     r_ptr, w_idx;
  logic              r_killed;
  logic [TAG_W-1:0]  r_inflight_tag;
  logic              r_cdb_req;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [63:0]       r_cdb_data;
  logic              w_buf_free, w_done, w_can_issue, w_capture, w_issue;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_can_issue),
    .o_grant (req_ready),
    .o_idx   (w_idx)
  );

  assign w_issue      = |req_ready;
  assign mul_valid_in = w_issue;
  assign mul_a        = w_issue ? req_a[w_idx] : '0;
  assign mul_b        = w_issue ? req_b[w_idx] : '0;
  assign cdb_req      = r_cdb_req;
  assign cdb_tag      = r_cdb_tag;
  assign cdb_data     = r_cdb_data;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      // A product already sitting at the multiplier output has nothing left
      // to wait for, so a flushed op is dropped right away in that case.
      if (r_state == HOLD || w_done) w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_issue) w_state_nxt = BUSY;
        BUSY: if (mul_valid_out)
                w_state_nxt = (r_killed || w_buf_free) ? (w_issue ? BUSY : IDLE) : HOLD;
        HOLD: if (cdb_grant) w_state_nxt = w_issue ? BUSY : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_buf_free  = ~r_cdb_req | cdb_grant;
    w_done      = (r_state == BUSY) & mul_valid_out;
    // rst gating keeps the multiplier quiet while the parent holds reset.
    w_can_issue = rst & ~flush & ((r_state == IDLE) | (w_done & w_buf_free) |
                                  ((r_state == HOLD) & cdb_grant));
    w_capture   = ~flush & ((w_done & ~r_killed & w_buf_free) |
                            ((r_state == HOLD) & cdb_grant));
    busy        = (r_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr          <= '0;
      r_killed       <= 1'b0;
      r_inflight_tag <= '0;
      r_cdb_req      <= 1'b0;
      r_cdb_tag      <= '0;
      r_cdb_data     <= '0;
    end else begin
      if (w_issue) begin
        r_ptr          <= w_idx + PW'(1);
        r_inflight_tag <= req_tag[w_idx];
        r_killed       <= 1'b0;
      end else if (flush && r_state == BUSY) begin
        r_killed <= 1'b1;
      end
      // Capture reads the old inflight tag even when a new issue overwrites it.
      if (flush) r_cdb_req <= 1'b0;
      else if (w_capture) begin
        r_cdb_req  <= 1'b1;
        r_cdb_tag  <= r_inflight_tag;
        r_cdb_data <= mul_out;
      end else if (cdb_grant) r_cdb_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mul_scheduler.sv
module tb_mul_scheduler;
  import mul_sched_pkg::*;
  localparam int N  = 4;
  localparam int TW = 6;

  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0][63:0]     req_a = '0, req_b = '0;
  logic [N-1:0][TW-1:0]   req_tag = '0;
  logic [N-1:0]           req_ready;
  logic                   mul_valid_in;
  logic [63:0]            mul_a, mul_b;
  logic                   mvo = 1'b0;
  logic [63:0]            mprod = '0;
  int                     mcnt = 0;
  logic                   cdb_req, busy;
  logic [TW-1:0]          cdb_tag;
  logic [63:0]            cdb_data;
  logic                   cdb_grant = 1'b0, flush = 1'b0;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mul_scheduler #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag), .req_ready(req_ready), .mul_valid_in(mul_valid_in),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid_out(mvo), .mul_out(mprod),
    .cdb_req(cdb_req), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_grant(cdb_grant), .flush(flush), .busy(busy));

  // Environment multiplier: start at edge T, done level from cycle T+5.
  always @(posedge clk) begin
    if (!rst) begin mvo <= 1'b0; mcnt <= 0; mprod <= '0; end
    else if (mul_valid_in) begin mvo <= 1'b0; mcnt <= 4; mprod <= mul_a * mul_b; end
    else if (mcnt != 0) begin mcnt <= mcnt - 1; if (mcnt == 1) mvo <= 1'b1; end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an op owns the multiplier until its result is moved
  // to the buffer or discarded; the buffer is a single optional slot.
  logic          m_own = 0, m_kill = 0, m_bv = 0;
  logic [TW-1:0] m_tag = '0, m_itag = '0;
  logic [63:0]   m_data = '0, m_iprod = '0;
  int            m_ptr = 0, e_g, e_idx;
  logic          e_can, e_iss, e_done, e_cap;
  logic [N-1:0]  e_ready;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_can = rst && !flush && (!m_own || (mvo && (!m_bv || cdb_grant)));
      e_g = -1;
      for (int k = 0; k < N; k++) begin
        e_idx = (m_ptr + k) % N;
        if (e_g < 0 && req_valid[e_idx]) e_g = e_idx;
      end
      e_iss   = e_can && (e_g >= 0);
      e_ready = '0;
      if (e_iss) e_ready[e_g] = 1'b1;
      chk("m_req_ready", 64'(req_ready), 64'(e_ready));
      chk("m_mul_valid_in", 64'(mul_valid_in), 64'(e_iss));
      if (e_iss) begin
        chk("m_mul_a", mul_a, req_a[e_g]);
        chk("m_mul_b", mul_b, req_b[e_g]);
      end
      chk("m_cdb_req", 64'(cdb_req), 64'(m_bv));
      chk("m_cdb_tag", 64'(cdb_tag), 64'(m_tag));
      chk("m_cdb_data", cdb_data, m_data);
      chk("m_busy", 64'(busy), 64'(m_own));
      if (!rst) begin
        m_own = 0; m_kill = 0; m_bv = 0; m_tag = '0; m_data = '0; m_ptr = 0;
      end else begin
        e_done = m_own && mvo;
        e_cap  = !flush && e_done && !m_kill && (!m_bv || cdb_grant);
        if (flush) m_bv = 0;
        else if (e_cap) begin m_bv = 1; m_tag = m_itag; m_data = m_iprod; end
        else if (cdb_grant) m_bv = 0;
        if (flush) begin
          if (e_done) m_own = 0;
          else if (m_own) m_kill = 1;
        end else if (e_done && (m_kill || e_cap)) m_own = 0;
        if (e_iss) begin
          m_own = 1; m_kill = 0; m_itag = req_tag[e_g];
          m_iprod = req_a[e_g] * req_b[e_g];
          m_ptr = (e_g + 1) % N;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int gi[$], gc[$];

  initial begin
    rst = 0; cyc(2); rst = 1; #1;
    chk("rst_cdb_req", 64'(cdb_req), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cdb_data", cdb_data, 0);
    chk("rst_cdb_tag", 64'(cdb_tag), 0);

    // Single op: requester 2, 3*7, tag 5
    req_valid = 4'b0100; req_a[2] = 3; req_b[2] = 7; req_tag[2] = 5; #1;
    chk("t1_ready", 64'(req_ready), 64'h4);
    chk("t1_start", 64'(mul_valid_in), 1);
    chk("t1_mul_a", mul_a, 3);
    cyc(1); req_valid = '0;
    cyc(4); #1; chk("t1_no_cdb_t5", 64'(cdb_req), 0);
    cyc(1); #1;
    chk("t1_cdb_req", 64'(cdb_req), 1);
    chk("t1_cdb_tag", 64'(cdb_tag), 5);
    chk("t1_cdb_data", cdb_data, 21);
    cdb_grant = 1;
    cyc(1); cdb_grant = 0; #1; chk("t1_cleared", 64'(cdb_req), 0);

    // Backpressure: A buffered, B completes into HOLD, grant pulse moves B and issues C
    req_valid = 4'b0001; req_a[0] = 6; req_b[0] = 7; req_tag[0] = 11; #1;
    chk("t3_a_ready", 64'(req_ready), 64'h1);
    cyc(1); req_valid = '0;
    cyc(4); req_valid = 4'b0010; req_a[1] = 5; req_b[1] = 9; req_tag[1] = 12; #1;
    chk("t3_b_ready", 64'(req_ready), 64'h2);
    cyc(1); req_valid = 4'b1000; req_a[3] = 2; req_b[3] = 8; req_tag[3] = 13; #1;
    chk("t3_a_cdb_data", cdb_data, 42);
    chk("t3_a_cdb_tag", 64'(cdb_tag), 11);
    cyc(4); #1; chk("t3_full_no_ready", 64'(req_ready), 0);
    cyc(1); #1;
    chk("t3_hold_busy", 64'(busy), 1);
    chk("t3_hold_no_ready", 64'(req_ready), 0);
    cyc(1); cdb_grant = 1; #1;
    chk("t3_c_ready", 64'(req_ready), 64'h8);
    chk("t3_c_mul_a", mul_a, 2);
    cyc(1); cdb_grant = 0; req_valid = '0; #1;
    chk("t3_b_cdb_req", 64'(cdb_req), 1);
    chk("t3_b_cdb_tag", 64'(cdb_tag), 12);
    chk("t3_b_cdb_data", cdb_data, 45);
    cyc(6); cdb_grant = 1; #1; chk("t3_c_hold", 64'(busy), 1);
    cyc(1); #1;
    chk("t3_c_cdb_tag", 64'(cdb_tag), 13);
    chk("t3_c_cdb_data", cdb_data, 16);
    cyc(1); cdb_grant = 0; #1;
    chk("t3_drained", 64'(cdb_req), 0);
    chk("t3_idle", 64'(busy), 0);

    // Flush mid-flight at T+2, new issue at T+5
    req_valid = 4'b0001; req_a[0] = 4; req_b[0] = 4; req_tag[0] = 30; #1;
    chk("t4_ready", 64'(req_ready), 64'h1);
    cyc(1); req_valid = '0;
    cyc(1); flush = 1;
    cyc(1); flush = 0; #1; chk("t4_killed_busy", 64'(busy), 1);
    cyc(2); req_valid = 4'b0010; req_a[1] = 9; req_b[1] = 9; req_tag[1] = 31; #1;
    chk("t4_reissue_ready", 64'(req_ready), 64'h2);
    chk("t4_reissue_a", mul_a, 9);
    cyc(1); req_valid = '0; #1; chk("t4_no_cdb", 64'(cdb_req), 0);
    cyc(5); #1;
    chk("t4_cdb_tag", 64'(cdb_tag), 31);
    chk("t4_cdb_data", cdb_data, 81);
    cdb_grant = 1; cyc(1); cdb_grant = 0;

    // Flush with buffered result and simultaneous grant
    req_valid = 4'b0100; req_a[2] = 3; req_b[2] = 3; req_tag[2] = 40;
    cyc(1); req_valid = '0;
    cyc(5); #1; chk("t5_buffered", 64'(cdb_req), 1);
    flush = 1; cdb_grant = 1;
    req_valid = 4'b0100; req_a[2] = 11; req_b[2] = 2; req_tag[2] = 41; #1;
    chk("t5_flush_no_ready", 64'(req_ready), 0);
    chk("t5_flush_no_start", 64'(mul_valid_in), 0);
    cyc(1); flush = 0; cdb_grant = 0; #1;
    chk("t5_cleared", 64'(cdb_req), 0);
    chk("t5_issue_after", 64'(req_ready), 64'h4);
    cyc(1); req_valid = '0;
    cyc(5); #1;
    chk("t5_cdb_data", cdb_data, 22);
    chk("t5_cdb_tag", 64'(cdb_tag), 41);
    cdb_grant = 1; cyc(1); cdb_grant = 0;

    // Reset during BUSY at T+3
    req_valid = 4'b0001; req_a[0] = 7; req_b[0] = 7; req_tag[0] = 50; #1;
    chk("t6_ready", 64'(req_ready), 64'h1);
    cyc(1); req_valid = '0;
    cyc(2); rst = 0;
    cyc(1); rst = 1; #1;
    chk("t6_busy0", 64'(busy), 0);
    chk("t6_cdb_req0", 64'(cdb_req), 0);
    chk("t6_cdb_data0", cdb_data, 0);
    chk("t6_cdb_tag0", 64'(cdb_tag), 0);
    chk("t6_start0", 64'(mul_valid_in), 0);
    req_valid = 4'b1100; req_a[2] = 12; req_b[2] = 12; req_tag[2] = 51; #1;
    chk("t6_lowest_valid", 64'(req_ready), 64'h4);
    cyc(1); req_valid = '0;
    cyc(5); #1; chk("t6_cdb_data", cdb_data, 144);
    cdb_grant = 1; cyc(1); cdb_grant = 0;

    // Round-robin from a fresh reset, all valid, CDB always granting
    rst = 0; cyc(1); rst = 1;
    for (int i = 0; i < N; i++) begin
      req_a[i] = 64'(i + 10); req_b[i] = 64'(i + 100); req_tag[i] = TW'(i + 20);
    end
    req_valid = '1; cdb_grant = 1;
    for (int c = 0; c < 21; c++) begin
      #1;
      if (mul_valid_in)
        for (int i = 0; i < N; i++) if (req_ready[i]) begin gi.push_back(i); gc.push_back(c); end
      cyc(1);
    end
    req_valid = '0;
    chk("rr_count", 64'(gi.size()), 5);
    for (int k = 0; k < gi.size() && k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), 64'(gi[k]), 64'(k % 4));
      chk($sformatf("rr_cycle%0d", k), 64'(gc[k]), 64'(5 * k));
    end
    cyc(8); cdb_grant = 0; cyc(1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mul_scheduler.md
# mul_scheduler

Issue scheduler and result buffer for the shared 64-bit iterative multiplier in the out-of-order core. It arbitrates round-robin among NUM_REQ reservation-station requesters and issues one operation at a time. It tracks the multiplier's completion, captures the 64-bit product with its tag into a one-entry result buffer, and presents it to the CDB. It never re-drives the multiplier while an operation is in flight, and it discards in-flight work on flush.

## Interface
- NUM_REQ, 4, number of requesters (power of 2, ≥2)
- TAG_W, 6, ROB/destination tag width
- clk  in  1  rising-edge clock; only clock
- rst  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has an operand pair ready
- req_a, req_b  in  NUM_REQ×64  operands per requester
- req_tag  in  NUM_REQ×TAG_W  destination tag per requester
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- mul_valid_in  out  1  start pulse to multiplier (multiplier latches A/B on this edge)
- mul_a, mul_b  out  64  operands to multiplier
- mul_valid_out  in  1  multiplier done, level (held until next start)
- mul_out  in  64  product, low 64 bits, unsigned
- cdb_req  out  1  result buffer valid, requests CDB
- cdb_tag  out  TAG_W  tag of buffered result
- cdb_data  out  64  buffered product
- cdb_grant  in  1  CDB accepts buffered result this cycle
- flush  in  1  pipeline flush: kill in-flight and buffered ops
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE (multiplier free), BUSY (op in flight, waiting for mul_valid_out), HOLD (multiplier done, buffer full, waiting for cdb_grant).
- buf_free = ~cdb_req | cdb_grant.
- can_issue = ~flush & (IDLE | (BUSY & mul_valid_out & buf_free) | (HOLD & cdb_grant)).
- Arbitration: round-robin pointer ptr. The granted requester is the first i with req_valid[i], searching from ptr upward with wrap. req_ready is one-hot on that i only when can_issue. The grant is combinational and no-valid → no ready. On a transfer, ptr ← i+1 mod NUM_REQ.
- Issue: mul_valid_in = any transfer. mul_a/mul_b = the granted requester's operands, combinational in the same cycle. On the same edge the scheduler latches the tag into inflight_tag, clears killed, and enters BUSY.
- mul_valid_in is never high in BUSY without mul_valid_out. It is never high in HOLD without cdb_grant. The multiplier corrupts its operands if started mid-operation.
- Completion in BUSY with mul_valid_out:
  - killed=1: discard the result, go to IDLE, or to BUSY if a new issue happens in the same cycle.
  - buf_free: capture mul_out and inflight_tag into the buffer (cdb_req←1), then go to BUSY if issuing, else IDLE.
  - else: go to HOLD.
- HOLD and cdb_grant: capture into the buffer the same cycle, then go to BUSY if issuing, else IDLE. mul_out stays valid through the issue cycle because the multiplier latches its operands only at the edge.
- cdb_grant with no capture that cycle: cdb_req←0.
- Flush (highest priority, same cycle):
  - No issue in the flush cycle.
  - The result buffer is cleared (cdb_req←0) even if cdb_grant is also high.
  - In BUSY, killed←1.
  - In HOLD, discard and go to IDLE.
  - ptr is unchanged.
- Arithmetic: the product passes through unmodified. The scheduler performs no sign or width adjustment.

## Timing
- Reset (rst=0 at an edge) sets: state IDLE, ptr 0, killed 0, cdb_req 0, cdb_tag 0, cdb_data 0, busy 0. req_ready/mul_valid_in are then 0 until rst=1.
- Reset mid-operation abandons the op. The parent must reset the multiplier in the same cycle.
- Issue in cycle T; mul_valid_out first high in T+5; capture at end of T+5; cdb_req high from T+6.
- Minimum issue spacing is 5 cycles: back-to-back issue in T+5 when buf_free.
- The result buffer holds its value stable while cdb_req=1 and cdb_grant=0.

## Structure
- Package mul_sched_pkg: state enum {IDLE, BUSY, HOLD} and the default TAG_W constant.
- One sub-module, rr_arbiter (NUM_REQ): inputs req vector, ptr and enable; outputs one-hot grant and index. ptr update stays in mul_scheduler.

## Test plan
- **Single op:** requester 2 valid, A=3, B=7, tag=5. Expected: req_ready=0100 in T, mul_valid_in in T, cdb_req in T+6 with tag 5 and data 21, cleared after cdb_grant.
- **Round-robin:** all four requesters continuously valid, cdb_grant always 1. Expected: grants 0,1,2,3,0, issued 5 cycles apart, back-to-back in the completion cycle.
- **CDB backpressure:** cdb_grant=0 with one result buffered and a second op completing. Expected: state HOLD, no req_ready. When cdb_grant pulses, the second result is captured the same cycle, cdb_req stays 1 with the new tag, and a new issue occurs in that cycle.
- **Flush mid-flight:** flush at T+2. Expected: no cdb_req for that op, state IDLE at T+6, next issue allowed from T+5 with correct data.
- **Flush with buffered result and simultaneous cdb_grant:** cdb_req=0 next cycle, no issue in the flush cycle.
- **Reset during BUSY:** rst=0 at T+3. Expected: all outputs 0 and ptr 0 next cycle, and the first post-reset grant goes to the lowest valid requester.
